gf_pow_engine: RTL and testbench
================================

Name: gf_pow_engine

Overview:
- Sequential, parametrised power-map engine: computes y = x^e in GF(2^N) for a runtime exponent e, using MSB-first square-and-multiply, one exponent bit per clock.
- Successor to the fixed-exponent combinational power-map S-boxes: width, field polynomial and exponent are no longer hard-wired.
- Sits behind a valid/ready stream. It serves S-box prototyping (e.g. e=38 in GF(2^6)) and inversion (e = 2^N-2).
- Operates in polynomial basis; any basis isomorphism is external.

Parameters:
- N, 6, field degree and width of x, e and y; legal range 2..16.
- POLY, 7'h43, modulus (N+1 bits, bit N set; default x^6+x+1). Elaboration error if bit N is clear.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  engine can accept; high only in IDLE.
- in_x  input  N  base element.
- in_e  input  N  exponent, unsigned, 0..2^N-1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_y  output  N  result x^e.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values (asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, out_y=0. Internal acc, x_r, e_r and bit counter are also 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: x_r<=in_x, e_r<=in_e, acc<=1, cnt<=N-1, go to RUN.
- RUN, each cycle:
  - sq = acc*acc mod POLY.
  - acc <= e_r[cnt] ? sq*x_r mod POLY : sq.
  - If cnt==0, go to DONE; else cnt<=cnt-1.
  - Exactly N RUN cycles, independent of exponent value; no early exit, to keep constant time.
- DONE:
  - out_valid=1, out_y=acc, held stable until out_ready.
  - On out_valid&out_ready, go to IDLE.
- Latency: out_valid rises N clocks after the accept edge. Throughput is one result per N+2 cycles with out_ready tied high.
- in_ready=0 in RUN and DONE. No accept in the DONE-to-IDLE cycle.
- out_y is registered (acc); no combinational path from inputs to outputs.
- Arithmetic:
  - Multiplication is carry-less with reduction by POLY.
  - 0^0 = 1; 0^e = 0 for e>0; 1^e = 1.
  - e = 2^N-1 gives 1 for x≠0 and 0 for x=0.
  - e = 2^N-2 gives the inverse, with 0 mapped to 0.
- in_x/in_e changes while not accepted are ignored.
- out_ready asserted outside DONE is ignored.
- Reset mid-RUN or mid-DONE aborts immediately: the result is discarded and out_valid drops asynchronously.

Decomposition:
- Package gf_pow_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the default polynomial constant GF6_POLY = 7'h43;
  - a function gf_mul_ref(a,b,poly,n) for bench reference use.
- Sub-module gf_mul (combinational, parameters N and POLY: a, b → a*b mod POLY) is instantiated twice, once as squarer and once as multiplier.

Test Plan:
- Reset then idle: all outputs at reset values. x=2, e=38 accepted at edge 0 → out_valid rises at edge 6, out_y=27 (0x1B).
- x=2, e=6 → 3. x=2, e=7 → 6. x=2, e=63 → 1. x=0, e=0 → 1. x=0, e=5 → 0. x=1, e=42 → 1.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. Check out_y stays stable, in_ready=0 and a new in_valid is not accepted. Release → IDLE, then next request accepted.
- Assert rst at RUN cycle 3 → out_valid=0, in_ready=1 immediately. A following request x=2, e=38 completes normally with 27.
- Random sweep, N=6, 2000 requests with random out_ready: compare against gf_mul_ref square-and-multiply. Check x^(63-1)*x = 1 for all x≠0.
- Generalisation: N=8, POLY=9'h11B, x=0x53, e=254 → 0xCA (AES inverse); x=0x02, e=8 → 0x1B.

Source files
------------

// File: rtl/gf_pow_pkg.sv
// -----------------------------------------------------------------------------
// gf_pow_pkg: shared types and constants for the GF(2^N) power-map engine.
//   state_t    : engine FSM states (IDLE / RUN / DONE)
//   GF6_POLY   : default field modulus x^6 + x + 1
//   gf_mul_ref : behavioural carry-less multiply with reduction; up to N=16,
//                intended as a reference model for benches
// -----------------------------------------------------------------------------
package gf_pow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] GF6_POLY = 7'h43;

  // MSB-first shift-and-add multiply in GF(2^n); a and b must fit in n bits.
  function automatic logic [15:0] gf_mul_ref(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [16:0] poly,
                                             input int          n);
    logic [16:0] p;
    p = 17'd0;
    for (int i = n - 1; i >= 0; i--) begin
      p = p << 1;
      if (p[n]) begin
        p = p ^ poly;
      end else begin
        p = p;
      end
      if (b[i]) begin
        p = p ^ {1'b0, a};
      end else begin
        p = p;
      end
    end
    return p[15:0];
  endfunction

endpackage

// File: rtl/gf_mul.sv
// -----------------------------------------------------------------------------
// gf_mul: combinational multiplier in GF(2^N), polynomial basis.
//   a, b : N-bit field elements
//   p    : a*b reduced modulo POLY
// -----------------------------------------------------------------------------
module gf_mul #(
  parameter int         N    = 6,
  parameter logic [N:0] POLY = 7'h43
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);

  // Horner evaluation over b's bits: shift, fold the overflow bit back in via
  // the low bits of the modulus, then conditionally add a.
  always_comb begin
    p = {N{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      p = {p[N-2:0], 1'b0} ^ (p[N-1] ? POLY[N-1:0] : {N{1'b0}});
      p = p ^ (b[i] ? a : {N{1'b0}});
    end
  end

endmodule

// File: rtl/gf_pow_engine.sv
// -----------------------------------------------------------------------------
// gf_pow_engine: y = x^e in GF(2^N) via MSB-first square-and-multiply, one
// exponent bit per clock, always exactly N RUN cycles (constant time).
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : request handshake (in_ready high only in IDLE)
//   in_x, in_e           : base element and unsigned exponent
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   out_y                : registered result, held until accepted
//   busy                 : high in RUN or DONE
// -----------------------------------------------------------------------------
module gf_pow_engine
  import gf_pow_pkg::*;
#(
  parameter int         N    = 6,
  parameter logic [N:0] POLY = GF6_POLY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_e,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic         busy
);

  localparam int CW = $clog2(N);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("gf_pow_engine: N must be in 2..16");
  end
  if (POLY[N] != 1'b1) begin : g_bad_poly
    $error("gf_pow_engine: POLY must have bit N set");
  end

  state_t          state;
  state_t          state_next;
  logic            load;
  logic            step;
  logic [N-1:0]    acc;
  logic [N-1:0]    x_r;
  logic [N-1:0]    e_r;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    sq;
  logic [N-1:0]    sq_x;
  logic [N-1:0]    acc_next;

  gf_mul #(.N(N), .POLY(POLY)) u_square (
    .a (acc),
    .b (acc),
    .p (sq)
  );

  gf_mul #(.N(N), .POLY(POLY)) u_mult (
    .a (sq),
    .b (x_r),
    .p (sq_x)
  );

  assign acc_next = e_r[cnt] ? sq_x : sq;
  assign out_y    = acc;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = RUN;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == {CW{1'b0}}) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake/status flags registered from the next state so they line up
  // with the state register and never see a combinational input path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

  // Operand capture and one square(-and-multiply) step per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= {N{1'b0}};
      x_r <= {N{1'b0}};
      e_r <= {N{1'b0}};
      cnt <= {CW{1'b0}};
    end else if (load) begin
      acc <= {{(N-1){1'b0}}, 1'b1};
      x_r <= in_x;
      e_r <= in_e;
      cnt <= CW'(N - 1);
    end else if (step) begin
      acc <= acc_next;
      if (cnt != {CW{1'b0}}) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gf_pow_engine.sv
module tb_gf_pow_engine;
  import gf_pow_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_x = 6'd0;
  logic [5:0] in_e = 6'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_y;
  logic       busy;

  logic       v8 = 1'b0;
  logic       r8;
  logic [7:0] x8 = 8'd0;
  logic [7:0] e8 = 8'd0;
  logic       ov8;
  logic [7:0] y8;
  logic       b8;

  int n_vec = 0;
  int n_err = 0;
  int ready_mode = 1;  // 0 = hold low, 1 = hold high, 2 = random

  typedef struct {logic [5:0] x; logic [5:0] y; bit inv;} exp_t;
  exp_t q[$];

  typedef struct {logic [5:0] x; logic [5:0] e; logic [5:0] y;} vec_t;
  vec_t vt[10];

  always #5 clk = ~clk;

  gf_pow_engine #(.N(6), .POLY(7'h43)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_e(in_e), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .busy(busy)
  );

  gf_pow_engine #(.N(8), .POLY(9'h11B)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
    .in_x(x8), .in_e(e8), .out_valid(ov8), .out_ready(1'b1),
    .out_y(y8), .busy(b8)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] pow_ref(input logic [5:0] x, input logic [5:0] e);
    logic [15:0] a;
    a = 16'd1;
    for (int i = 5; i >= 0; i--) begin
      a = gf_mul_ref(a, a, 17'h43, 6);
      if (e[i]) a = gf_mul_ref(a, {10'd0, x}, 17'h43, 6);
    end
    return a[5:0];
  endfunction

  // Consumer ready pattern, changed away from both clock edges.
  always begin
    @(posedge clk);
    #2;
    out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  // Scoreboard monitor: compare every accepted result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", 16'(out_valid), 16'd0);
      end else begin
        exp_t it;
        it = q.pop_front();
        check("out_y", 16'(out_y), 16'(it.y));
        if (it.inv) check("inv_prod", gf_mul_ref(16'(out_y), 16'(it.x), 17'h43, 6), 16'd1);
      end
    end
  end

  // Drive one request; returns #1 after the accepting edge.
  task automatic send(input logic [5:0] x, input logic [5:0] e, input logic [5:0] y,
                      input bit inv, input bit push);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x = x;
    in_e = e;
    for (int t = 0; t < 500; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 16'd0, 16'd1);
    else if (push) q.push_back('{x, y, inv});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x = 6'($urandom);
    in_e = 6'($urandom);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (q.size() == 0 && in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 16'd0, 16'd1);
  endtask

  task automatic send8(input logic [7:0] x, input logic [7:0] e, input logic [7:0] y);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    v8 = 1'b1; x8 = x; e8 = e;
    for (int t = 0; t < 50; t++) begin
      if (r8) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 v8 = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (ov8) begin ok = 1'b1; break; end
      end
    end
    if (!ok) check("n8_timeout", 16'd0, 16'd1);
    else check("n8_out_y", 16'(y8), 16'(y));
  endtask

  initial begin
    int k;
    logic [5:0] held;
    vt[0] = '{6'd2, 6'd38, 6'd27};
    vt[1] = '{6'd2, 6'd6,  6'd3};
    vt[2] = '{6'd2, 6'd7,  6'd6};
    vt[3] = '{6'd2, 6'd63, 6'd1};
    vt[4] = '{6'd0, 6'd0,  6'd1};
    vt[5] = '{6'd0, 6'd5,  6'd0};
    vt[6] = '{6'd1, 6'd42, 6'd1};
    vt[7] = '{6'd2, 6'd62, 6'd33};
    vt[8] = '{6'd0, 6'd62, 6'd0};
    vt[9] = '{6'd0, 6'd63, 6'd0};

    // Reset values, during and after reset.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_out_y", 16'(out_y), 16'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 16'(in_ready), 16'd1);
    check("idle_out_valid", 16'(out_valid), 16'd0);

    // Latency: accept at edge 0, out_valid at edge 6.
    ready_mode = 1;
    send(6'd2, 6'd38, 6'd27, 1'b0, 1'b1);
    check("run_busy", 16'(busy), 16'd1);
    check("run_in_ready", 16'(in_ready), 16'd0);
    k = 0;
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin k = t; break; end
    end
    check("latency", 16'(k), 16'd6);
    drain();

    // Table vectors.
    foreach (vt[i]) send(vt[i].x, vt[i].e, vt[i].y, 1'b0, 1'b1);
    drain();

    // Back-pressure: result held, new requests ignored.
    ready_mode = 0;
    send(6'd2, 6'd38, 6'd27, 1'b0, 1'b1);
    k = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin k = 1; break; end
    end
    check("bp_valid_seen", 16'(k), 16'd1);
    held = out_y;
    in_valid = 1'b1; in_x = 6'd5; in_e = 6'd3;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("bp_out_y", 16'(out_y), 16'(held));
      check("bp_out_valid", 16'(out_valid), 16'd1);
      check("bp_in_ready", 16'(in_ready), 16'd0);
    end
    in_valid = 1'b0;
    ready_mode = 1;
    drain();
    send(6'd5, 6'd3, 6'd22, 1'b0, 1'b1);
    drain();

    // Reset at RUN cycle 3.
    send(6'd2, 6'd38, 6'd27, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", 16'(out_valid), 16'd0);
    check("abort_in_ready", 16'(in_ready), 16'd1);
    check("abort_busy", 16'(busy), 16'd0);
    @(negedge clk) rst = 1'b0;
    send(6'd2, 6'd38, 6'd27, 1'b0, 1'b1);
    drain();

    // Reset while holding a result in DONE.
    ready_mode = 0;
    send(6'd3, 6'd9, 6'd0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    check("done_valid", 16'(out_valid), 16'd1);
    #1 rst = 1'b1;
    #1 check("done_abort_valid", 16'(out_valid), 16'd0);
    @(negedge clk) rst = 1'b0;
    ready_mode = 1;

    // Random sweep with random back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      logic [5:0] rx, re;
      rx = 6'($urandom);
      re = 6'($urandom);
      send(rx, re, pow_ref(rx, re), 1'b0, 1'b1);
    end
    drain();

    // x^62 * x == 1 for every nonzero x.
    for (int x = 1; x < 64; x++) send(6'(x), 6'd62, pow_ref(6'(x), 6'd62), 1'b1, 1'b1);
    drain();

    // N=8 AES field.
    send8(8'h53, 8'd254, 8'hCA);
    send8(8'h02, 8'd8, 8'h1B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
